// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between N_REQ byte producers.
// Round-robin grant in IDLE, one-cycle run pulse in ISSUE, then WAIT holds
// off the next grant for FRAME_CYCLES cycles while the UART shifts the frame.

// Per-requester acceptance decode: one lane per requester.
module uart_tx_arb_lane #(
  parameter int ID_W = 2,
  parameter int LANE = 0
) (
  input  logic            grant,
  input  logic [ID_W-1:0] win,
  output logic            ready
);
  assign ready = grant && (win == ID_W'(LANE));
endmodule

module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int FRAME_CYCLES = 10,
  parameter int ID_W         = $clog2(N_REQ)
) (
  input  logic               CLK,
  input  logic               ASYNCRESETN,
  input  logic               enable,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               run,
  output logic [7:0]         message,
  output logic               busy,
  output logic [ID_W-1:0]    grant_id,
  output logic [15:0]        frame_count
);

  localparam int CNT_W = $clog2(FRAME_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t                  state, state_nxt;
  logic                    grant;
  logic [ID_W-1:0]         last;
  logic [CNT_W-1:0]        cnt;
  logic [N_REQ-1:0]        rot;
  logic [ID_W-1:0]         j;
  logic [ID_W:0]           sum;
  logic [ID_W-1:0]         win;
  logic [N_REQ-1:0][7:0]   data_v;

  assign data_v = req_data;

  // Rotate valids so bit 0 is the requester right after the last winner.
  assign rot = N_REQ'({req_valid, req_valid} >> ({1'b0, last} + 1'b1));

  // Lowest set bit of the rotated vector is the round-robin winner offset.
  always_comb begin
    j = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (rot[k]) j = ID_W'(k);
  end

  // Undo the rotation: winner = (last + 1 + j) mod N_REQ, at most one wrap.
  assign sum = {1'b0, last} + {1'b0, j} + 1'b1;
  assign win = (sum >= (ID_W+1)'(N_REQ)) ? ID_W'(sum - (ID_W+1)'(N_REQ))
                                          : sum[ID_W-1:0];

  // FSM state register.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  // Next-state logic; grant only in IDLE with enable and a pending request.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && (|req_valid)) begin
          grant     = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (cnt == '0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // One-hot acceptance pulse, combinational from the grant decision.
  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    uart_tx_arb_lane #(.ID_W(ID_W), .LANE(g)) u_lane (
      .grant (grant),
      .win   (win),
      .ready (req_ready[g])
    );
  end

  // Registered outputs, RR pointer and frame timer.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      run         <= 1'b0;
      message     <= 8'h00;
      busy        <= 1'b0;
      grant_id    <= '0;
      frame_count <= 16'd0;
      cnt         <= '0;
      last        <= ID_W'(N_REQ - 1);
    end else begin
      // run is high exactly in ISSUE, busy whenever the FSM is not IDLE.
      run  <= grant;
      busy <= (state_nxt != ST_IDLE);
      if (grant) begin
        message  <= data_v[win];
        grant_id <= win;
        last     <= win;
      end
      case (state)
        ST_ISSUE: begin
          cnt         <= CNT_W'(FRAME_CYCLES - 1);
          frame_count <= frame_count + 16'd1;
        end
        ST_WAIT: if (cnt != '0) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N_REQ=4, FRAME_CYCLES=10).
module tb_uart_tx_arbiter;

  logic        CLK = 1'b0;
  logic        ASYNCRESETN = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        run;
  logic [7:0]  message;
  logic        busy;
  logic [1:0]  grant_id;
  logic [15:0] frame_count;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int prev_run = 0;
  int n;
  logic quiet;

  uart_tx_arbiter #(.N_REQ(4), .FRAME_CYCLES(10)) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .run         (run),
    .message     (message),
    .busy        (busy),
    .grant_id    (grant_id),
    .frame_count (frame_count)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Advance until run is seen (bounded), then check grant and byte.
  task automatic wait_run(input string tag, input logic [1:0] gid, input logic [7:0] msg,
                          input bit check_gap);
    int k = 0;
    while (!run && k < 40) begin
      tick();
      k++;
    end
    chk({tag, "_seen"}, {31'd0, run}, 32'd1);
    chk({tag, "_gid"}, {30'd0, grant_id}, {30'd0, gid});
    chk({tag, "_msg"}, {24'd0, message}, {24'd0, msg});
    if (check_gap) chk({tag, "_gap"}, cyc - prev_run, 32'd12);
    prev_run = cyc;
  endtask

  // Count cycles busy stays high, starting from a cycle where it is high.
  task automatic count_busy(output int cnt_o);
    cnt_o = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (!busy) break;
      cnt_o++;
    end
  endtask

  initial begin
    // Reset held for 3 cycles.
    repeat (3) @(negedge CLK);
    chk("rst_run", {31'd0, run}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_msg", {24'd0, message}, 32'd0);
    chk("rst_fc", {16'd0, frame_count}, 32'd0);
    ASYNCRESETN = 1'b1;
    enable = 1'b1;

    // Idle with no requests for 20 cycles.
    quiet = 1'b1;
    repeat (20) begin
      tick();
      if (run || busy || (req_ready != 4'b0) || (frame_count != 16'd0)) quiet = 1'b0;
    end
    chk("idle_quiet", {31'd0, quiet}, 32'd1);

    // Single request from requester 2.
    req_valid = 4'b0100;
    req_data[23:16] = 8'hA5;
    #1;
    chk("single_ready", {28'd0, req_ready}, 32'h4);
    tick();
    req_valid = 4'b0000;
    chk("single_run", {31'd0, run}, 32'd1);
    chk("single_msg", {24'd0, message}, 32'hA5);
    chk("single_gid", {30'd0, grant_id}, 32'd2);
    chk("single_ready_off", {28'd0, req_ready}, 32'd0);
    count_busy(n);
    chk("single_busy_len", n, 32'd11);
    chk("single_fc", {16'd0, frame_count}, 32'd1);

    // Reset so requester 0 has priority again, then all four continuously valid.
    ASYNCRESETN = 1'b0;
    tick();
    ASYNCRESETN = 1'b1;
    req_data = 32'h13121110;
    req_valid = 4'b1111;
    #1;
    chk("rr_ready0", {28'd0, req_ready}, 32'h1);
    wait_run("rr0", 2'd0, 8'h10, 1'b0); tick();
    wait_run("rr1", 2'd1, 8'h11, 1'b1); tick();
    wait_run("rr2", 2'd2, 8'h12, 1'b1); tick();
    wait_run("rr3", 2'd3, 8'h13, 1'b1); tick();
    wait_run("rr4", 2'd0, 8'h10, 1'b1); tick();
    chk("rr_fc", {16'd0, frame_count}, 32'd5);

    // Fairness: after grant 1 only 0 and 1 valid -> 0 then 1.
    wait_run("fair_a", 2'd1, 8'h11, 1'b1);
    req_valid = 4'b0011;
    tick();
    wait_run("fair_b", 2'd0, 8'h10, 1'b1); tick();
    wait_run("fair_c", 2'd1, 8'h11, 1'b1);

    // Enable dropped during the frame: frame completes, no new grant.
    enable = 1'b0;
    req_valid = 4'b1111;
    count_busy(n);
    chk("en_busy_len", n, 32'd11);
    quiet = 1'b1;
    repeat (5) begin
      if (run || busy || (req_ready != 4'b0)) quiet = 1'b0;
      tick();
    end
    chk("en_blocked", {31'd0, quiet}, 32'd1);
    enable = 1'b1;
    #1;
    chk("en_ready", {28'd0, req_ready}, 32'h4);
    tick();
    chk("en_run", {31'd0, run}, 32'd1);
    chk("en_gid", {30'd0, grant_id}, 32'd2);

    // Async reset in the middle of WAIT, between clock edges.
    repeat (3) tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    chk("pre_rst_fc", {16'd0, frame_count}, 32'd9);
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_run", {31'd0, run}, 32'd0);
    chk("arst_msg", {24'd0, message}, 32'd0);
    chk("arst_fc", {16'd0, frame_count}, 32'd0);
    chk("arst_gid", {30'd0, grant_id}, 32'd0);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    #1;
    chk("post_rst_ready", {28'd0, req_ready}, 32'h1);
    tick();
    chk("post_rst_run", {31'd0, run}, 32'd1);
    chk("post_rst_gid", {30'd0, grant_id}, 32'd0);
    chk("post_rst_msg", {24'd0, message}, 32'h10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
